serial_mod_n: RTL and testbench

- Parametrised successor to the serial divide-by-3 checker.
- Accepts an MSB-first digit stream, W bits per beat, and tracks the running value modulo any DIVISOR.
- Adds valid qualification, frame delimiting (sof/eof) and a registered per-frame result.
- Sits on serial data paths as a checksum / divisibility monitor.

---
 rtl/serial_mod_pkg.sv | 22 ++
 rtl/serial_mod_step_chain.sv | 27 ++
 rtl/serial_mod_n.sv | 121 ++++++++++++
 tb/tb_serial_mod_n.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_mod_pkg.sv
// Shared types, limits and the single-bit remainder step for the serial modulo checker.
package serial_mod_pkg;

  localparam int DIVISOR_MIN = 2;
  localparam int DIVISOR_MAX = 256;
  localparam int W_MIN       = 1;
  localparam int W_MAX       = 8;
  localparam int MAX_RW      = 8;
  localparam int CNT_W       = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // r < divisor, so 2r+b < 2*divisor and a single conditional subtract suffices.
  function automatic logic [MAX_RW:0] mod_step(input logic [MAX_RW:0] r,
                                               input logic            b,
                                               input logic [MAX_RW:0] divisor);
    logic [MAX_RW+1:0] t;
    t = {r, b};
    if (t >= {1'b0, divisor}) t = t - {1'b0, divisor};
    return t[MAX_RW:0];
  endfunction

endpackage

// File: rtl/serial_mod_step_chain.sv
// Combinational W-deep chain of single-bit modulo steps: (base*2^W + x) mod DIVISOR.
module serial_mod_step_chain
  import serial_mod_pkg::*;
#(
  parameter int DIVISOR = 3,
  parameter int W       = 1,
  parameter int RW      = 2
) (
  input  logic [RW-1:0] base_i,
  input  logic [W-1:0]  x_i,
  output logic [RW-1:0] nxt_o
);

  localparam logic [MAX_RW:0] DIV_L = (MAX_RW+1)'(DIVISOR);

  logic [W:0][MAX_RW:0] r;

  assign r[0] = {{(MAX_RW+1-RW){1'b0}}, base_i};

  // MSB of the digit is absorbed first.
  for (genvar i = 0; i < W; i++) begin : g_step
    assign r[i+1] = mod_step(r[i], x_i[W-1-i], DIV_L);
  end

  assign nxt_o = r[W][RW-1:0];

endmodule

// File: rtl/serial_mod_n.sv
// Serial MSB-first modulo-DIVISOR monitor with sof/eof framing and registered frame result.
// Optional per-frame beat counter enabled by defining SERIAL_MOD_BEAT_CNT_EN.
module serial_mod_n
  import serial_mod_pkg::*;
#(
  parameter  int DIVISOR = 3,
  parameter  int W       = 1,
  localparam int RW      = $clog2(DIVISOR)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_i,
  input  logic          sof_i,
  input  logic          eof_i,
  input  logic [W-1:0]  x_i,
  output logic [RW-1:0] rem_o,
  output logic          div_o,
  output logic          res_valid_o,
  output logic [RW-1:0] res_rem_o,
  output logic          res_div_o
`ifdef SERIAL_MOD_BEAT_CNT_EN
  ,
  output logic [CNT_W-1:0] beat_cnt_o,
  output logic [CNT_W-1:0] res_beats_o
`endif
);

  if (DIVISOR < DIVISOR_MIN || DIVISOR > DIVISOR_MAX) begin : g_bad_divisor
    $error("serial_mod_n: DIVISOR out of range");
  end
  if (W < W_MIN || W > W_MAX) begin : g_bad_w
    $error("serial_mod_n: W out of range");
  end

  logic [RW-1:0] rem_q, rem_d, base, nxt;
  logic          res_valid_q, res_valid_d;
  logic [RW-1:0] res_rem_q, res_rem_d;
  logic          res_div_q, res_div_d;

  assign base = sof_i ? '0 : rem_q;

  serial_mod_step_chain #(.DIVISOR(DIVISOR), .W(W), .RW(RW)) u_chain (
    .base_i (base),
    .x_i    (x_i),
    .nxt_o  (nxt)
  );

  assign rem_o = valid_i ? nxt : rem_q;
  assign div_o = (rem_o == '0);

  always_comb begin
    rem_d       = rem_q;
    res_valid_d = 1'b0;
    res_rem_d   = res_rem_q;
    res_div_d   = res_div_q;
    if (valid_i) begin
      if (eof_i) begin
        rem_d       = '0;
        res_valid_d = 1'b1;
        res_rem_d   = nxt;
        res_div_d   = (nxt == '0);
      end else begin
        rem_d = nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q       <= '0;
      res_valid_q <= 1'b0;
      res_rem_q   <= '0;
      res_div_q   <= 1'b0;
    end else begin
      rem_q       <= rem_d;
      res_valid_q <= res_valid_d;
      res_rem_q   <= res_rem_d;
      res_div_q   <= res_div_d;
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_rem_o   = res_rem_q;
  assign res_div_o   = res_div_q;

`ifdef SERIAL_MOD_BEAT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base, cnt_view;
  logic [CNT_W-1:0] res_beats_q, res_beats_d;

  assign cnt_base = sof_i ? '0 : cnt_q;
  assign cnt_view = valid_i ? ((cnt_base == CNT_MAX) ? CNT_MAX : cnt_base + CNT_W'(1))
                            : cnt_q;

  always_comb begin
    cnt_d       = cnt_q;
    res_beats_d = res_beats_q;
    if (valid_i) begin
      if (eof_i) begin
        cnt_d       = '0;
        res_beats_d = cnt_view;
      end else begin
        cnt_d = cnt_view;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      res_beats_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      res_beats_q <= res_beats_d;
    end
  end

  assign beat_cnt_o  = cnt_view;
  assign res_beats_o = res_beats_q;
`endif

endmodule

// File: tb/tb_serial_mod_n.sv
// Bench for serial_mod_n: three configurations (3/1, 5/4, 7/2) against an arithmetic model.
module tb_serial_mod_n;

  logic clk, reset;
  logic       in_v[3], in_s[3], in_e[3];
  logic [7:0] in_x[3];

  logic [1:0] rem3, rrem3;
  logic [2:0] rem5, rrem5, rem7, rrem7;
  logic       div3, div5, div7, rv3, rv5, rv7, rd3, rd5, rd7;
`ifdef SERIAL_MOD_BEAT_CNT_EN
  logic [15:0] bc[3], rb[3];
`endif

  int n_tests = 0, n_fail = 0;

  serial_mod_n #(.DIVISOR(3), .W(1)) u_d3 (
    .clk(clk), .reset(reset), .valid_i(in_v[0]), .sof_i(in_s[0]), .eof_i(in_e[0]),
    .x_i(in_x[0][0:0]), .rem_o(rem3), .div_o(div3), .res_valid_o(rv3),
    .res_rem_o(rrem3), .res_div_o(rd3)
`ifdef SERIAL_MOD_BEAT_CNT_EN
    , .beat_cnt_o(bc[0]), .res_beats_o(rb[0])
`endif
  );

  serial_mod_n #(.DIVISOR(5), .W(4)) u_d5 (
    .clk(clk), .reset(reset), .valid_i(in_v[1]), .sof_i(in_s[1]), .eof_i(in_e[1]),
    .x_i(in_x[1][3:0]), .rem_o(rem5), .div_o(div5), .res_valid_o(rv5),
    .res_rem_o(rrem5), .res_div_o(rd5)
`ifdef SERIAL_MOD_BEAT_CNT_EN
    , .beat_cnt_o(bc[1]), .res_beats_o(rb[1])
`endif
  );

  serial_mod_n #(.DIVISOR(7), .W(2)) u_d7 (
    .clk(clk), .reset(reset), .valid_i(in_v[2]), .sof_i(in_s[2]), .eof_i(in_e[2]),
    .x_i(in_x[2][1:0]), .rem_o(rem7), .div_o(div7), .res_valid_o(rv7),
    .res_rem_o(rrem7), .res_div_o(rd7)
`ifdef SERIAL_MOD_BEAT_CNT_EN
    , .beat_cnt_o(bc[2]), .res_beats_o(rb[2])
`endif
  );

  int o_rem[3], o_div[3], o_rv[3], o_rr[3], o_rd[3];
  assign o_rem[0] = int'(rem3);  assign o_rem[1] = int'(rem5);  assign o_rem[2] = int'(rem7);
  assign o_div[0] = int'(div3);  assign o_div[1] = int'(div5);  assign o_div[2] = int'(div7);
  assign o_rv[0]  = int'(rv3);   assign o_rv[1]  = int'(rv5);   assign o_rv[2]  = int'(rv7);
  assign o_rr[0]  = int'(rrem3); assign o_rr[1]  = int'(rrem5); assign o_rr[2]  = int'(rrem7);
  assign o_rd[0]  = int'(rd3);   assign o_rd[1]  = int'(rd5);   assign o_rd[2]  = int'(rd7);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the frame value is tracked as a plain integer residue.
  int m_rem[3], m_rv[3], m_rr[3], m_rd[3], m_cnt[3], m_rb[3];

  function automatic int dv(int k);
    return (k == 0) ? 3 : (k == 1) ? 5 : 7;
  endfunction
  function automatic int wv(int k);
    return (k == 0) ? 1 : (k == 1) ? 4 : 2;
  endfunction
  function automatic int exp_nxt(int k);
    int base;
    base = in_s[k] ? 0 : m_rem[k];
    return (base * (1 << wv(k)) + int'(in_x[k])) % dv(k);
  endfunction
  function automatic int exp_rem(int k);
    return in_v[k] ? exp_nxt(k) : m_rem[k];
  endfunction
  function automatic int exp_cnt(int k);
    int base;
    base = in_s[k] ? 0 : m_cnt[k];
    if (!in_v[k]) return m_cnt[k];
    return (base >= 65535) ? 65535 : base + 1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 3; k++) begin
        m_rem[k] <= 0; m_rv[k] <= 0; m_rr[k] <= 0; m_rd[k] <= 0; m_cnt[k] <= 0; m_rb[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (in_v[k]) begin
          if (in_e[k]) begin
            m_rr[k]  <= exp_nxt(k);
            m_rd[k]  <= (exp_nxt(k) == 0) ? 1 : 0;
            m_rv[k]  <= 1;
            m_rem[k] <= 0;
            m_rb[k]  <= exp_cnt(k);
            m_cnt[k] <= 0;
          end else begin
            m_rem[k] <= exp_nxt(k);
            m_cnt[k] <= exp_cnt(k);
            m_rv[k]  <= 0;
          end
        end else begin
          m_rv[k] <= 0;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rem_o[%0d]", k), o_rem[k], exp_rem(k));
      chk($sformatf("div_o[%0d]", k), o_div[k], (exp_rem(k) == 0) ? 1 : 0);
      chk($sformatf("res_valid_o[%0d]", k), o_rv[k], m_rv[k]);
      chk($sformatf("res_rem_o[%0d]", k), o_rr[k], m_rr[k]);
      chk($sformatf("res_div_o[%0d]", k), o_rd[k], m_rd[k]);
`ifdef SERIAL_MOD_BEAT_CNT_EN
      chk($sformatf("beat_cnt_o[%0d]", k), int'(bc[k]), exp_cnt(k));
      chk($sformatf("res_beats_o[%0d]", k), int'(rb[k]), m_rb[k]);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int k, input bit v, input bit s, input bit e, input int x);
    for (int j = 0; j < 3; j++) begin
      in_v[j] = 1'b0; in_s[j] = 1'b0; in_e[j] = 1'b0; in_x[j] = 8'h00;
    end
    in_v[k] = v; in_s[k] = s; in_e[k] = e; in_x[k] = 8'(x);
  endtask

  logic [255:0] bigval;
  bit           rb_bit;

  initial begin
    reset = 1'b0;
    drv(0, 0, 0, 0, 0);
    cyc(); cyc();
    chk("reset rem3", o_rem[0], 0);
    chk("reset res_valid3", o_rv[0], 0);
    chk("reset res_div3", o_rd[0], 0);
    reset = 1'b1;
    cyc();

    // D=3 W=1: 1,1,0 = 6
    drv(0, 1, 1, 0, 1); #2 chk("t1 rem b0", o_rem[0], 1); cyc();
    drv(0, 1, 0, 0, 1); #2 chk("t1 rem b1", o_rem[0], 0); cyc();
    drv(0, 1, 0, 1, 0); #2 chk("t1 div last", o_div[0], 1); cyc();
    chk("t1 res_valid", o_rv[0], 1);
    chk("t1 res_rem", o_rr[0], 0);
    chk("t1 res_div", o_rd[0], 1);
    drv(0, 0, 0, 0, 0); cyc();
    chk("t1 res_valid drop", o_rv[0], 0);

    // D=5 W=4: 0x1, idle x3 with junk control, 0x9 = 25
    drv(1, 1, 1, 0, 1); cyc();
    for (int i = 0; i < 3; i++) begin
      drv(1, 0, 1, 1, 9); #2 chk("t2 idle hold", o_rem[1], 1); cyc();
    end
    drv(1, 1, 0, 1, 9); #2 chk("t2 rem last", o_rem[1], 0); cyc();
    chk("t2 res_rem", o_rr[1], 0);
    chk("t2 res_div", o_rd[1], 1);

    // D=7 W=2: single-beat frames back to back
    drv(2, 1, 1, 1, 3); #2 chk("t3 rem", o_rem[2], 3); chk("t3 div", o_div[2], 0); cyc();
    chk("t3 res_rem", o_rr[2], 3);
    chk("t3 res_div", o_rd[2], 0);
    drv(2, 1, 1, 1, 2); cyc();
    chk("t3 b2b valid", o_rv[2], 1);
    chk("t3 b2b res_rem", o_rr[2], 2);
    // eof without sof continues from accumulated remainder: 3,2,1 -> 57 mod 7 = 1
    drv(2, 1, 0, 0, 3); cyc();
    drv(2, 1, 0, 0, 2); cyc();
    drv(2, 1, 0, 1, 1); cyc();
    chk("t3 nosof res_rem", o_rr[2], 1);
    drv(2, 0, 0, 0, 0); cyc();

    // D=3 W=1: 100 random bits vs wide reference value
    bigval = '0;
    for (int i = 0; i < 100; i++) begin
      rb_bit = 1'($urandom_range(0, 1));
      bigval = {bigval[254:0], rb_bit};
      drv(0, 1, i == 0, i == 99, int'(rb_bit));
      #2;
      chk("t4 rand rem", o_rem[0], int'(bigval % 256'd3));
      chk("t4 rand div", o_div[0], (bigval % 256'd3 == 0) ? 1 : 0);
      cyc();
    end
    chk("t4 res_rem", o_rr[0], int'(bigval % 256'd3));
    drv(0, 0, 0, 0, 0); cyc();

    // Reset mid-frame after 1,0 (rem 2), then 1,1,0 eof without sof
    drv(0, 1, 1, 0, 1); cyc();
    drv(0, 1, 0, 0, 0); cyc();
    drv(0, 0, 0, 0, 0); #2 chk("t5 pre-reset rem", o_rem[0], 2);
    reset = 1'b0;
    #1;
    chk("t5 rst rem", o_rem[0], 0);
    chk("t5 rst div", o_div[0], 1);
    chk("t5 rst res_valid", o_rv[0], 0);
    chk("t5 rst res_rem", o_rr[0], 0);
    chk("t5 rst res_div", o_rd[0], 0);
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    drv(0, 1, 0, 0, 1); #2 chk("t5 restart rem", o_rem[0], 1); cyc();
    drv(0, 1, 0, 0, 1); cyc();
    drv(0, 1, 0, 1, 0); cyc();
    chk("t5 res_valid", o_rv[0], 1);
    chk("t5 res_rem", o_rr[0], 0);
    chk("t5 res_div", o_rd[0], 1);
    drv(0, 0, 0, 0, 0); cyc();

`ifdef SERIAL_MOD_BEAT_CNT_EN
    // 5 valid beats with two gaps on the D=5 instance
    drv(1, 1, 1, 0, 1); #2 chk("t6 cnt1", int'(bc[1]), 1); cyc();
    drv(1, 0, 0, 0, 0); #2 chk("t6 gap1", int'(bc[1]), 1); cyc();
    drv(1, 1, 0, 0, 2); #2 chk("t6 cnt2", int'(bc[1]), 2); cyc();
    drv(1, 1, 0, 0, 3); #2 chk("t6 cnt3", int'(bc[1]), 3); cyc();
    drv(1, 0, 0, 0, 0); #2 chk("t6 gap2", int'(bc[1]), 3); cyc();
    drv(1, 1, 0, 0, 4); #2 chk("t6 cnt4", int'(bc[1]), 4); cyc();
    drv(1, 1, 0, 1, 0); #2 chk("t6 cnt5", int'(bc[1]), 5); cyc();
    drv(1, 0, 0, 0, 0); #2;
    chk("t6 res_beats", int'(rb[1]), 5);
    chk("t6 cnt cleared", int'(bc[1]), 0);
    cyc();
`endif

    cyc(); cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
